// File: rtl/pipe_adder.sv
// pipe_adder: carry-chunked pipelined adder with valid/ready handshakes.
// WIDTH bits are split into STAGES chunks of CW = WIDTH/STAGES bits; stage k
// adds chunk k plus the carry left by stage k-1, and each item's operands
// travel with it so chunks of different items never mix.
// Optional feature: define PIPE_ADDER_SAT_EN to saturate sum on signed overflow.
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = WIDTH / STAGES;

`ifdef PIPE_ADDER_SAT_EN
  // Clamp to the signed extreme on the side the operands came from.
  function automatic logic [WIDTH-1:0] sat_sum(input logic [WIDTH-1:0] s,
                                               input logic             ovf,
                                               input logic             neg);
    if (!ovf)
      return s;
    return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] src_vld;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] ld;

  logic [WIDTH-1:0] a_st [STAGES];
  logic [WIDTH-1:0] b_st [STAGES];
  logic [WIDTH-1:0] s_st [STAGES];
  logic             c_st [STAGES];

  // Stage k moves when any stage from k to the output has a hole, or the
  // output is being taken; written in closed form to avoid a comb self-loop.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      adv[k] = out_ready;
      for (int j = k; j < STAGES; j++)
        if (!vld_q[j]) adv[k] = 1'b1;
    end
  end

  assign src_vld = STAGES'({vld_q, in_valid});
  assign ld      = adv & src_vld;
  assign vld_d   = (adv & src_vld) | (~adv & vld_q);

  // Stage valid bits; cleared immediately by reset so in-flight items vanish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      vld_q <= '0;
    else
      vld_q <= vld_d;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_in, b_in, s_in;
    logic             c_in;
    logic [CW:0]      chunk_d;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] a_q, b_q, s_q;
    logic             c_q;

    if (k == 0) begin : g_head
      assign a_in = a;
      assign b_in = b;
      assign s_in = '0;
      assign c_in = cin;
    end else begin : g_link
      assign a_in = a_st[k-1];
      assign b_in = b_st[k-1];
      assign s_in = s_st[k-1];
      assign c_in = c_st[k-1];
    end

    // Add this stage's chunk and splice it into the partial sum.
    always_comb begin
      chunk_d = {1'b0, a_in[k*CW +: CW]} + {1'b0, b_in[k*CW +: CW]} + {{CW{1'b0}}, c_in};
      s_d = s_in;
      s_d[k*CW +: CW] = chunk_d[CW-1:0];
    end

    if (k == STAGES-1) begin : g_out
      // Output stage: reset so sum/cout/overflow read zero, held while stalled.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
          c_q <= 1'b0;
        end else if (ld[k]) begin
          a_q <= a_in;
          b_q <= b_in;
          s_q <= s_d;
          c_q <= chunk_d[CW];
        end
      end
    end else begin : g_mid
      // Interior stage data: no reset needed, qualified by the valid bit.
      always_ff @(posedge clk) begin
        if (ld[k]) begin
          a_q <= a_in;
          b_q <= b_in;
          s_q <= s_d;
          c_q <= chunk_d[CW];
        end
      end
    end

    assign a_st[k] = a_q;
    assign b_st[k] = b_q;
    assign s_st[k] = s_q;
    assign c_st[k] = c_q;
  end

  logic a_msb, b_msb, s_msb;
  assign a_msb = a_st[STAGES-1][WIDTH-1];
  assign b_msb = b_st[STAGES-1][WIDTH-1];
  assign s_msb = s_st[STAGES-1][WIDTH-1];

  assign overflow  = (a_msb == b_msb) && (s_msb != a_msb);
  assign cout      = c_st[STAGES-1];
  assign out_valid = vld_q[STAGES-1];
  assign in_ready  = adv[0];

`ifdef PIPE_ADDER_SAT_EN
  assign sum = sat_sum(s_st[STAGES-1], overflow, a_msb);
`else
  assign sum = s_st[STAGES-1];
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder (WIDTH=16, STAGES=4): directed vector table, random
// back-to-back stream, backpressure fill/drain and mid-flight reset.
module tb_pipe_adder;

`ifdef PIPE_ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  typedef logic [17:0] res_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] a, b;
  logic        cin;
  logic        in_valid, in_ready;
  logic [15:0] sum;
  logic        cout, overflow;
  logic        out_valid, out_ready;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_out  = 0;
  res_t exp_q[$];

  pipe_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
    .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .cout(cout), .overflow(overflow),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] f;
    logic [15:0] s;
    logic        o;
    f = {1'b0, x} + {1'b0, y} + {16'b0, c};
    s = f[15:0];
    o = (x[15] == y[15]) && (s[15] != x[15]);
    if (SAT && o) s = x[15] ? 16'h8000 : 16'h7FFF;
    return {s, f[16], o};
  endfunction

  // One clock: drive, sample handshakes just before the edge, score outputs.
  task automatic step_io(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                         input logic ic, input logic ordy, output logic acc, output logic emit);
    res_t r;
    in_valid = iv; a = ia; b = ib; cin = ic; out_ready = ordy;
    #1;
    acc  = iv && in_ready;
    emit = out_valid && ordy;
    if (emit) begin
      if (exp_q.size() == 0) begin
        chk("out_valid_unexpected", 32'(out_valid), 32'd0);
      end else begin
        r = exp_q.pop_front();
        chk($sformatf("result_%0d", n_out), 32'({sum, cout, overflow}), 32'(r));
      end
      n_out++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t        tbl[10];
    logic        acc, emit;
    int          lat, first, last, nem, k;
    logic [15:0] x, y;
    logic        c;
    logic [15:0] bpa[6];
    logic [15:0] bpb[6];
    res_t        held;

    tbl[0] = '{a:16'h7FFF, b:16'h0001, cin:1'b0, sum:(SAT ? 16'h7FFF : 16'h8000), cout:1'b0, ovf:1'b1};
    tbl[1] = '{a:16'hFFFF, b:16'h0001, cin:1'b0, sum:16'h0000, cout:1'b1, ovf:1'b0};
    tbl[2] = '{a:16'h00FF, b:16'h0000, cin:1'b1, sum:16'h0100, cout:1'b0, ovf:1'b0};
    tbl[3] = '{a:16'h8000, b:16'h8000, cin:1'b0, sum:(SAT ? 16'h8000 : 16'h0000), cout:1'b1, ovf:1'b1};
    tbl[4] = '{a:16'h1234, b:16'h1111, cin:1'b0, sum:16'h2345, cout:1'b0, ovf:1'b0};
    tbl[5] = '{a:16'hFFFF, b:16'hFFFF, cin:1'b1, sum:16'hFFFF, cout:1'b1, ovf:1'b0};
    tbl[6] = '{a:16'h0FFF, b:16'h0001, cin:1'b1, sum:16'h1001, cout:1'b0, ovf:1'b0};
    tbl[7] = '{a:16'h8000, b:16'hFFFF, cin:1'b0, sum:(SAT ? 16'h8000 : 16'h7FFF), cout:1'b1, ovf:1'b1};
    tbl[8] = '{a:16'h4000, b:16'h4000, cin:1'b0, sum:(SAT ? 16'h7FFF : 16'h8000), cout:1'b0, ovf:1'b1};
    tbl[9] = '{a:16'h0000, b:16'h0000, cin:1'b0, sum:16'h0000, cout:1'b0, ovf:1'b0};

    bpa = '{16'h0101, 16'h7000, 16'h00FF, 16'hF00F, 16'h2222, 16'h3333};
    bpb = '{16'h0202, 16'h1000, 16'h0001, 16'h0FF1, 16'h1111, 16'h4444};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_sum",       32'(sum),       32'd0);
    chk("rst_cout",      32'(cout),      32'd0);
    chk("rst_overflow",  32'(overflow),  32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors, one at a time, with latency measurement.
    for (int i = 0; i < 10; i++) begin
      step_io(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, 1'b1, acc, emit);
      chk($sformatf("vec%0d_accept", i), 32'(acc), 32'd1);
      if (acc) exp_q.push_back({tbl[i].sum, tbl[i].cout, tbl[i].ovf});
      lat = 0; emit = 1'b0;
      while (!emit && lat < 10) begin
        lat++;
        step_io(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc, emit);
      end
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      exp_q.delete();
    end

    // 20 random items back to back, out_ready held high.
    first = -1; last = -1; nem = 0;
    for (int s = 0; s < 30; s++) begin
      x = 16'($urandom); y = 16'($urandom); c = 1'($urandom);
      step_io(s < 20, x, y, c, 1'b1, acc, emit);
      if (s < 20) chk($sformatf("stream_in_ready_%0d", s), 32'(acc), 32'd1);
      if (acc) exp_q.push_back(model(x, y, c));
      if (emit) begin
        if (first < 0) first = s;
        last = s;
        nem++;
      end
    end
    chk("stream_count", 32'(nem), 32'd20);
    chk("stream_consecutive", 32'(last - first), 32'd19);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // Backpressure: fill to 4, stall, then drain with acceptance resuming.
    k = 0; held = '0;
    for (int i = 0; i < 8; i++) begin
      step_io(1'b1, bpa[k], bpb[k], 1'b0, 1'b0, acc, emit);
      if (acc) begin
        exp_q.push_back(model(bpa[k], bpb[k], 1'b0));
        k++;
      end
      if (i == 4) begin
        chk("bp_in_ready_full", 32'(acc), 32'd0);
        held = {sum, cout, overflow};
      end
    end
    chk("bp_accepted", 32'(k), 32'd4);
    chk("bp_out_valid_held", 32'(out_valid), 32'd1);
    chk("bp_data_stable", 32'({sum, cout, overflow}), 32'(held));
    step_io(1'b1, bpa[k], bpb[k], 1'b0, 1'b1, acc, emit);
    chk("bp_resume_in_ready", 32'(acc), 32'd1);
    chk("bp_resume_emit", 32'(emit), 32'd1);
    if (acc) begin
      exp_q.push_back(model(bpa[k], bpb[k], 1'b0));
      k++;
    end
    for (int i = 0; i < 20 && exp_q.size() > 0; i++)
      step_io(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc, emit);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // Reset with 3 items in flight; none may reappear.
    for (int i = 0; i < 3; i++) begin
      step_io(1'b1, bpa[i], bpb[i], 1'b1, 1'b0, acc, emit);
      if (acc) exp_q.push_back(model(bpa[i], bpb[i], 1'b1));
    end
    step_io(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, acc, emit);
    chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
    chk("mid_rst_sum",       32'(sum),       32'd0);
    chk("mid_rst_overflow",  32'(overflow),  32'd0);
    exp_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    nem = 0;
    for (int i = 0; i < 10; i++) begin
      step_io(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc, emit);
      if (emit) nem++;
    end
    chk("post_rst_no_output", 32'(nem), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
